// File: rtl/vga_scaled_display.sv
// VGA timing engine with integer-scaled frame-buffer addressing and a sync/blank delay line
// that lines the pins up with frame-buffer data returned READ_LATENCY pixel ticks after the address.
module vga_scaled_display #(
    parameter int unsigned ColorBits    = 3,
    parameter int unsigned screenX      = 320,
    parameter int unsigned screenY      = 240,
    parameter int unsigned SCALE_SHIFT  = 1,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          SYNC_POL     = 1'b0,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_X_W     = 9,
    parameter int unsigned ADDR_Y_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ColorBits-1:0] readValueMemory,
    input  logic [23:0]          border_color,
    output logic [ADDR_X_W-1:0]  XRead,
    output logic [ADDR_Y_W-1:0]  YRead,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 pixel_tick,
    output logic                 frame_start
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW     = $clog2(HTotal);
    localparam int unsigned VW     = $clog2(VTotal);
    localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned K      = ColorBits / 3;
    localparam int unsigned L      = READ_LATENCY;
    localparam bit          SyncOff = ~SYNC_POL;

    // Repeat the k-bit channel MSB-first so full scale maps to 8'hFF.
    function automatic logic [7:0] expand(input logic [K-1:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = c[K-1-(i%K)];
        end
        return r;
    endfunction

    logic          run_q;
    logic          tick;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h_ext, v_ext, hx, vy;
    logic          hs_now, vs_now, act_now, img_now, org_now;

    logic [ADDR_X_W-1:0] xread_q, xread_d;
    logic [ADDR_Y_W-1:0] yread_q, yread_d;

    logic [L-1:0] dl_hs_q, dl_hs_d, dl_vs_q, dl_vs_d;
    logic [L-1:0] dl_act_q, dl_act_d, dl_img_q, dl_img_d, dl_org_q, dl_org_d;

    logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fs_q, fs_d;
    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    // run_q keeps pixel_tick low in the clock right after reset, even with CLK_DIV=1.
    assign tick = run_q && (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (run_q) begin
            div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            if (h_q == HW'(HTotal - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(VTotal - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_ext   = 32'(h_q);
        v_ext   = 32'(v_q);
        hx      = h_ext >> SCALE_SHIFT;
        vy      = v_ext >> SCALE_SHIFT;
        hs_now  = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
        vs_now  = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
        act_now = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        img_now = act_now && (hx < screenX) && (vy < screenY);
        org_now = (h_q == '0) && (v_q == '0);
        xread_d = img_now ? hx[ADDR_X_W-1:0] : '0;
        yread_d = img_now ? vy[ADDR_Y_W-1:0] : '0;
    end

    // Sync bits travel at pin level so reset can park them at the idle level.
    always_comb begin
        dl_hs_d     = dl_hs_q;
        dl_vs_d     = dl_vs_q;
        dl_act_d    = dl_act_q;
        dl_img_d    = dl_img_q;
        dl_org_d    = dl_org_q;
        dl_hs_d[0]  = hs_now ? SYNC_POL : SyncOff;
        dl_vs_d[0]  = vs_now ? SYNC_POL : SyncOff;
        dl_act_d[0] = act_now;
        dl_img_d[0] = img_now;
        dl_org_d[0] = org_now;
        for (int i = 1; i < int'(L); i++) begin
            dl_hs_d[i]  = dl_hs_q[i-1];
            dl_vs_d[i]  = dl_vs_q[i-1];
            dl_act_d[i] = dl_act_q[i-1];
            dl_img_d[i] = dl_img_q[i-1];
            dl_org_d[i] = dl_org_q[i-1];
        end
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        blank_d = blank_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (tick) begin
            hsync_d = dl_hs_q[L-1];
            vsync_d = dl_vs_q[L-1];
            blank_d = dl_act_q[L-1];
            if (dl_img_q[L-1]) begin
                red_d   = expand(readValueMemory[3*K-1 -: K]);
                green_d = expand(readValueMemory[2*K-1 -: K]);
                blue_d  = expand(readValueMemory[K-1:0]);
            end else if (dl_act_q[L-1]) begin
                red_d   = border_color[23:16];
                green_d = border_color[15:8];
                blue_d  = border_color[7:0];
            end else begin
                red_d   = 8'h00;
                green_d = 8'h00;
                blue_d  = 8'h00;
            end
        end
        fs_d = tick && dl_org_q[L-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            xread_q  <= '0;
            yread_q  <= '0;
            dl_hs_q  <= {L{SyncOff}};
            dl_vs_q  <= {L{SyncOff}};
            dl_act_q <= '0;
            dl_img_q <= '0;
            dl_org_q <= '0;
            hsync_q  <= SyncOff;
            vsync_q  <= SyncOff;
            blank_q  <= 1'b0;
            red_q    <= 8'h00;
            green_q  <= 8'h00;
            blue_q   <= 8'h00;
            fs_q     <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            fs_q    <= fs_d;
            if (tick) begin
                xread_q  <= xread_d;
                yread_q  <= yread_d;
                dl_hs_q  <= dl_hs_d;
                dl_vs_q  <= dl_vs_d;
                dl_act_q <= dl_act_d;
                dl_img_q <= dl_img_d;
                dl_org_q <= dl_org_d;
            end
        end
    end

    assign XRead       = xread_q;
    assign YRead       = yread_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign pixel_tick  = tick;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scaled_display.sv
// Directed bench: four configurations share one clock/reset; checks are placed at edge
// counts since reset release, hand-derived from the pixel/line timing.
module tb_vga_scaled_display;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] border = 24'h123456;
    int          ecount = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    // Defaults: CLK_DIV=2, READ_LATENCY=1.
    logic [8:0] x_def; logic [7:0] y_def; logic [2:0] rv_def;
    logic hs_def, vs_def, bl_def, pt_def, fs_def; logic [7:0] r_def, g_def, b_def;
    assign rv_def = (x_def == 9'd2 && y_def == 8'd3) ? 3'b101 : 3'b010;

    vga_scaled_display u_def (
        .clock(clock), .reset(reset), .readValueMemory(rv_def), .border_color(border),
        .XRead(x_def), .YRead(y_def), .hsync(hs_def), .vsync(vs_def), .blank(bl_def),
        .red(r_def), .green(g_def), .blue(b_def), .pixel_tick(pt_def), .frame_start(fs_def)
    );

    // Narrow image: border columns 600..639.
    logic [8:0] x_brd; logic [7:0] y_brd; logic [2:0] rv_brd;
    logic hs_brd, vs_brd, bl_brd, pt_brd, fs_brd; logic [7:0] r_brd, g_brd, b_brd;
    assign rv_brd = 3'b111;

    vga_scaled_display #(.screenX(300), .CLK_DIV(1)) u_brd (
        .clock(clock), .reset(reset), .readValueMemory(rv_brd), .border_color(border),
        .XRead(x_brd), .YRead(y_brd), .hsync(hs_brd), .vsync(vs_brd), .blank(bl_brd),
        .red(r_brd), .green(g_brd), .blue(b_brd), .pixel_tick(pt_brd), .frame_start(fs_brd)
    );

    // Three-tick read latency.
    logic [8:0] x_lat; logic [7:0] y_lat; logic [2:0] rv_lat;
    logic hs_lat, vs_lat, bl_lat, pt_lat, fs_lat; logic [7:0] r_lat, g_lat, b_lat;
    assign rv_lat = 3'b111;

    vga_scaled_display #(.READ_LATENCY(3), .CLK_DIV(1)) u_lat (
        .clock(clock), .reset(reset), .readValueMemory(rv_lat), .border_color(border),
        .XRead(x_lat), .YRead(y_lat), .hsync(hs_lat), .vsync(vs_lat), .blank(bl_lat),
        .red(r_lat), .green(g_lat), .blue(b_lat), .pixel_tick(pt_lat), .frame_start(fs_lat)
    );

    // Tiny 24x12 raster, 2 bits/channel, active-high sync, 6x3 image.
    logic [8:0] x_sm; logic [7:0] y_sm; logic [5:0] rv_sm;
    logic hs_sm, vs_sm, bl_sm, pt_sm, fs_sm; logic [7:0] r_sm, g_sm, b_sm;
    assign rv_sm = (x_sm == 9'd1 && y_sm == 8'd1) ? 6'b10_01_11 : 6'b00_00_00;

    vga_scaled_display #(
        .ColorBits(6), .SYNC_POL(1'b1), .CLK_DIV(1), .screenX(6), .screenY(3),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_sm (
        .clock(clock), .reset(reset), .readValueMemory(rv_sm), .border_color(border),
        .XRead(x_sm), .YRead(y_sm), .hsync(hs_sm), .vsync(vs_sm), .blank(bl_sm),
        .red(r_sm), .green(g_sm), .blue(b_sm), .pixel_tick(pt_sm), .frame_start(fs_sm)
    );

    task automatic goto(input int k);
        int spins = 0;
        while (ecount < k) begin
            @(negedge clock);
            spins++;
            if (spins > 50000) begin
                $display("FAIL goto_timeout: edge count %0d, required %0d", ecount, k);
                $fatal(1, "edge budget exhausted");
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({x_def, y_def, r_def, g_def, b_def, bl_def, fs_def, pt_def, hs_def, vs_def}
            !== {9'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_def: got x%0d y%0d rgb %h%h%h bl%b fs%b pt%b hs%b vs%b",
                     x_def, y_def, r_def, g_def, b_def, bl_def, fs_def, pt_def, hs_def, vs_def);
        end
        n_cmp++;
        if ({hs_sm, vs_sm, pt_sm, bl_sm} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_small: got hs%b vs%b pt%b bl%b, want 0000",
                     hs_sm, vs_sm, pt_sm, bl_sm);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick;
        goto(1);
        n_cmp++; if (pt_def !== 1'b0) begin n_bad++; $display("FAIL tick_e1_def: got %b want 0", pt_def); end
        n_cmp++; if (pt_sm !== 1'b1) begin n_bad++; $display("FAIL tick_e1_div1: got %b want 1", pt_sm); end
        goto(2);
        n_cmp++; if (pt_def !== 1'b1) begin n_bad++; $display("FAIL tick_e2_def: got %b want 1", pt_def); end
        goto(3);
        n_cmp++; if (pt_def !== 1'b0) begin n_bad++; $display("FAIL tick_e3_def: got %b want 0", pt_def); end
    endtask

    task automatic test_frame_start;
        // ecount is already 3 here
        n_cmp++; if (fs_sm !== 1'b1) begin n_bad++; $display("FAIL fs_small_e3: got %b want 1", fs_sm); end
        n_cmp++; if (fs_def !== 1'b0) begin n_bad++; $display("FAIL fs_def_e3: got %b want 0", fs_def); end
        goto(4);
        n_cmp++; if (fs_sm !== 1'b0) begin n_bad++; $display("FAIL fs_small_e4: got %b want 0", fs_sm); end
        n_cmp++; if ({bl_lat, fs_lat} !== 2'b00) begin n_bad++; $display("FAIL lat_early: got bl%b fs%b want 00", bl_lat, fs_lat); end
        goto(5);
        n_cmp++; if (fs_def !== 1'b1) begin n_bad++; $display("FAIL fs_def_e5: got %b want 1", fs_def); end
        n_cmp++;
        if ({bl_def, r_def, g_def, b_def} !== {1'b1, 24'h00FF00}) begin
            n_bad++; $display("FAIL px00_def: got bl%b %h%h%h want 1 00FF00", bl_def, r_def, g_def, b_def);
        end
        n_cmp++; if ({bl_lat, fs_lat} !== 2'b11) begin n_bad++; $display("FAIL lat_first: got bl%b fs%b want 11", bl_lat, fs_lat); end
        goto(6);
        n_cmp++; if ({fs_def, fs_lat} !== 2'b00) begin n_bad++; $display("FAIL fs_pulse_end: got %b%b want 00", fs_def, fs_lat); end
    endtask

    task automatic test_small_border;
        goto(15);
        n_cmp++;
        if ({bl_sm, r_sm, g_sm, b_sm, x_sm} !== {1'b1, 24'h123456, 9'd0}) begin
            n_bad++; $display("FAIL small_border_col: got bl%b %h%h%h x%0d want 1 123456 x0", bl_sm, r_sm, g_sm, b_sm, x_sm);
        end
        goto(19);
        n_cmp++;
        if ({bl_sm, r_sm, g_sm, b_sm} !== 25'd0) begin
            n_bad++; $display("FAIL small_porch: got bl%b %h%h%h want 0 000000", bl_sm, r_sm, g_sm, b_sm);
        end
    endtask

    task automatic test_sync_pol;
        goto(20); n_cmp++; if (hs_sm !== 1'b0) begin n_bad++; $display("FAIL hs_pol_h17: got %b want 0", hs_sm); end
        goto(21); n_cmp++; if ({hs_sm, vs_sm} !== 2'b10) begin n_bad++; $display("FAIL hs_pol_h18: got %b%b want 10", hs_sm, vs_sm); end
        goto(23); n_cmp++; if (hs_sm !== 1'b1) begin n_bad++; $display("FAIL hs_pol_h20: got %b want 1", hs_sm); end
        goto(24); n_cmp++; if (hs_sm !== 1'b0) begin n_bad++; $display("FAIL hs_pol_h21: got %b want 0", hs_sm); end
    endtask

    task automatic test_colour_k2;
        goto(52);
        n_cmp++;
        if ({bl_sm, r_sm, g_sm, b_sm} !== {1'b1, 24'h000000}) begin
            n_bad++; $display("FAIL k2_prev_px: got bl%b %h%h%h want 1 000000", bl_sm, r_sm, g_sm, b_sm);
        end
        goto(53);
        n_cmp++;
        if ({bl_sm, r_sm, g_sm, b_sm} !== {1'b1, 24'hAA55FF}) begin
            n_bad++; $display("FAIL k2_expand: got bl%b %h%h%h want 1 AA55FF", bl_sm, r_sm, g_sm, b_sm);
        end
    endtask

    task automatic test_border_row;
        goto(147);
        n_cmp++;
        if ({bl_sm, r_sm, g_sm, b_sm, y_sm} !== {1'b1, 24'h123456, 8'd0}) begin
            n_bad++; $display("FAIL small_border_row: got bl%b %h%h%h y%0d want 1 123456 y0", bl_sm, r_sm, g_sm, b_sm, y_sm);
        end
    endtask

    task automatic test_vsync_wrap;
        goto(218); n_cmp++; if (vs_sm !== 1'b0) begin n_bad++; $display("FAIL vs_v8: got %b want 0", vs_sm); end
        goto(219); n_cmp++; if (vs_sm !== 1'b1) begin n_bad++; $display("FAIL vs_v9: got %b want 1", vs_sm); end
        goto(266); n_cmp++; if (vs_sm !== 1'b1) begin n_bad++; $display("FAIL vs_v10: got %b want 1", vs_sm); end
        goto(267); n_cmp++; if (vs_sm !== 1'b0) begin n_bad++; $display("FAIL vs_v11: got %b want 0", vs_sm); end
        goto(290); n_cmp++; if (fs_sm !== 1'b0) begin n_bad++; $display("FAIL wrap_fs_pre: got %b want 0", fs_sm); end
        goto(291); n_cmp++; if (fs_sm !== 1'b1) begin n_bad++; $display("FAIL wrap_fs: got %b want 1", fs_sm); end
        goto(292); n_cmp++; if (fs_sm !== 1'b0) begin n_bad++; $display("FAIL wrap_fs_post: got %b want 0", fs_sm); end
    endtask

    task automatic test_border_wide;
        goto(601); n_cmp++; if (x_brd !== 9'd299) begin n_bad++; $display("FAIL brd_addr_599: got %0d want 299", x_brd); end
        goto(602);
        n_cmp++; if ({x_brd, y_brd} !== 17'd0) begin n_bad++; $display("FAIL brd_addr_600: got x%0d y%0d want 0 0", x_brd, y_brd); end
        n_cmp++; if ({bl_brd, r_brd} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL brd_img_599: got bl%b r%h want 1 FF", bl_brd, r_brd); end
        goto(603);
        n_cmp++;
        if ({bl_brd, r_brd, g_brd, b_brd} !== {1'b1, 24'h123456}) begin
            n_bad++; $display("FAIL brd_col_600: got bl%b %h%h%h want 1 123456", bl_brd, r_brd, g_brd, b_brd);
        end
        goto(642);
        n_cmp++;
        if ({bl_brd, r_brd, g_brd, b_brd} !== {1'b1, 24'h123456}) begin
            n_bad++; $display("FAIL brd_col_639: got bl%b %h%h%h want 1 123456", bl_brd, r_brd, g_brd, b_brd);
        end
        goto(643);
        n_cmp++;
        if ({bl_brd, r_brd, g_brd, b_brd} !== 25'd0) begin
            n_bad++; $display("FAIL brd_col_640: got bl%b %h%h%h want 0 000000", bl_brd, r_brd, g_brd, b_brd);
        end
    endtask

    task automatic test_latency_hsync;
        goto(660); n_cmp++; if (hs_lat !== 1'b1) begin n_bad++; $display("FAIL lat_hs_655: got %b want 1", hs_lat); end
        goto(661); n_cmp++; if (hs_lat !== 1'b0) begin n_bad++; $display("FAIL lat_hs_656: got %b want 0", hs_lat); end
        goto(756); n_cmp++; if (hs_lat !== 1'b0) begin n_bad++; $display("FAIL lat_hs_751: got %b want 0", hs_lat); end
        goto(757); n_cmp++; if (hs_lat !== 1'b1) begin n_bad++; $display("FAIL lat_hs_752: got %b want 1", hs_lat); end
    endtask

    task automatic test_hsync_def;
        goto(1316); n_cmp++; if (hs_def !== 1'b1) begin n_bad++; $display("FAIL hs_def_655: got %b want 1", hs_def); end
        goto(1317); n_cmp++; if (hs_def !== 1'b0) begin n_bad++; $display("FAIL hs_def_656: got %b want 0", hs_def); end
        goto(1508); n_cmp++; if (hs_def !== 1'b0) begin n_bad++; $display("FAIL hs_def_751: got %b want 0", hs_def); end
        goto(1509); n_cmp++; if (hs_def !== 1'b1) begin n_bad++; $display("FAIL hs_def_752: got %b want 1", hs_def); end
        goto(2916); n_cmp++; if (hs_def !== 1'b1) begin n_bad++; $display("FAIL hs_def_l1_655: got %b want 1", hs_def); end
        goto(2917); n_cmp++; if (hs_def !== 1'b0) begin n_bad++; $display("FAIL hs_def_l1_656: got %b want 0", hs_def); end
    endtask

    task automatic test_pixel_def;
        goto(11211);
        n_cmp++;
        if ({bl_def, r_def, g_def, b_def} !== {1'b1, 24'h00FF00}) begin
            n_bad++; $display("FAIL px_h3v7: got bl%b %h%h%h want 1 00FF00", bl_def, r_def, g_def, b_def);
        end
        goto(11213);
        n_cmp++; if ({x_def, y_def} !== {9'd2, 8'd3}) begin n_bad++; $display("FAIL addr_h5v7: got x%0d y%0d want 2 3", x_def, y_def); end
        goto(11214);
        n_cmp++; if (r_def !== 8'hFF) begin n_bad++; $display("FAIL px_hold: got %h want FF", r_def); end
        goto(11215);
        n_cmp++;
        if ({bl_def, r_def, g_def, b_def} !== {1'b1, 24'hFF00FF}) begin
            n_bad++; $display("FAIL px_h5v7: got bl%b %h%h%h want 1 FF00FF", bl_def, r_def, g_def, b_def);
        end
    endtask

    task automatic test_mid_reset;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({x_def, y_def, r_def, g_def, b_def, bl_def, fs_def, pt_def, hs_def, vs_def}
            !== {9'd0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL midreset_def: got x%0d y%0d rgb %h%h%h bl%b fs%b pt%b hs%b vs%b",
                     x_def, y_def, r_def, g_def, b_def, bl_def, fs_def, pt_def, hs_def, vs_def);
        end
        n_cmp++;
        if ({hs_sm, vs_sm, pt_sm} !== 3'b000) begin
            n_bad++; $display("FAIL midreset_small: got hs%b vs%b pt%b want 000", hs_sm, vs_sm, pt_sm);
        end
        reset = 1'b0;
        goto(3);
        n_cmp++; if (fs_sm !== 1'b1) begin n_bad++; $display("FAIL midreset_fs_small: got %b want 1", fs_sm); end
        goto(5);
        n_cmp++; if ({fs_def, bl_def} !== 2'b11) begin n_bad++; $display("FAIL midreset_fs_def: got fs%b bl%b want 11", fs_def, bl_def); end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_frame_start();
        test_small_border();
        test_sync_pol();
        test_colour_k2();
        test_border_row();
        test_vsync_wrap();
        test_border_wide();
        test_latency_hsync();
        test_hsync_def();
        test_pixel_def();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scaled_display.md
Name: vga_scaled_display

Overview:
- Parametrised next-generation VGA display engine: generates pixel tick, H/V timing, integer-scaled frame-buffer read addresses and 8-bit RGB output in one clock domain.
- Compensates a configurable frame-buffer read latency by delaying sync/blank to match returned pixel data.
- Supports a border colour outside the scaled image window, selectable sync polarity, and a frame-start pulse for the drawing logic.
- Sits between the frame-buffer memory and the ADV-style DAC pins.

Parameters:
- ColorBits, 3: pixel word width; 3*k bits, k bits per channel, R in MSBs, B in LSBs.
- screenX, 320: frame-buffer width in pixels.
- screenY, 240: frame-buffer height in pixels.
- SCALE_SHIFT, 1: each frame-buffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT display pixels.
- H_ACTIVE, H_FP, H_SYNC, H_BP: 640, 16, 96, 48 (H_TOTAL 800).
- V_ACTIVE, V_FP, V_SYNC, V_BP: 480, 10, 2, 33 (V_TOTAL 525).
- SYNC_POL, 0: sync asserted level (0 = active-low).
- CLK_DIV, 2: system clocks per pixel, >=1.
- READ_LATENCY, 1: pixel ticks from XRead/YRead change to valid readValueMemory, >=1.
- ADDR_X_W, 9 / ADDR_Y_W, 8: address widths.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- readValueMemory  in  ColorBits  frame-buffer data for the address issued READ_LATENCY ticks earlier
- border_color  in  24  {R,G,B} shown inside the active area but outside the image window
- XRead  out  ADDR_X_W  frame-buffer column
- YRead  out  ADDR_Y_W  frame-buffer row
- hsync  out  1  horizontal sync, SYNC_POL level when asserted
- vsync  out  1  vertical sync
- blank  out  1  high = video on (DAC BLANK_N)
- red, green, blue  out  8 each  pixel colour
- pixel_tick  out  1  one-clock pulse per pixel
- frame_start  out  1  one-clock pulse at h=0,v=0

Behaviour:
- Divider counts 0..CLK_DIV-1; pixel_tick=1 on the clock where the divider equals CLK_DIV-1. With CLK_DIV=1, pixel_tick is constantly 1 after reset. All other state advances only on pixel_tick.
- h_count wraps 0..H_TOTAL-1; v_count increments when h_count wraps and itself wraps 0..V_TOTAL-1.
- Sync and active conditions, computed from the counters:
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - active = h<H_ACTIVE && v<V_ACTIVE.
- Image window: in_img = active && (h>>SCALE_SHIFT)<screenX && (v>>SCALE_SHIFT)<screenY.
- Address stage, registered on the tick that counter value n is current:
  - XRead = h>>SCALE_SHIFT and YRead = v>>SCALE_SHIFT, truncated to width, when in_img.
  - Otherwise XRead and YRead hold 0.
- Delay line: hsync, vsync, active and in_img pass through a READ_LATENCY-deep shift register clocked by pixel_tick.
- Output stage: on tick n+READ_LATENCY, red/green/blue/hsync/vsync/blank are registered from the delayed flags and readValueMemory. Pins therefore lag the address by exactly READ_LATENCY ticks.
- Colour selection:
  - in_img: each k-bit channel is replicated MSB-first to fill 8 bits (k=1: 0->8'h00, 1->8'hFF; k=2: 2'b10->8'hAA).
  - active && !in_img: border_color.
  - !active: RGB=0 and blank=0.
- frame_start is a one-clock pulse on the output-stage tick whose delayed counter was h=0,v=0, i.e. aligned to the pins.
- Reset (synchronous, any cycle including mid-frame):
  - Divider, counters and all pipeline registers clear to 0.
  - XRead=0, YRead=0, RGB=0, blank=0, frame_start=0, pixel_tick=0.
  - hsync and vsync go to their deasserted level (~SYNC_POL).
  - Delay-line sync bits clear to the deasserted level.
  - The first tick after reset release starts at h=0,v=0.
- Boundaries:
  - At h=H_TOTAL-1,v=V_TOTAL-1 both counters wrap on the same tick.
  - A border column exists when screenX<<SCALE_SHIFT < H_ACTIVE (not with defaults).
  - readValueMemory is ignored whenever the delayed in_img is 0.

Test Plan:
- Defaults, reset held 3 clocks then released -> pixel_tick every 2nd clock; hsync low for 96 ticks starting at tick 656 of each line; line period 1600 clocks; vsync low for 2 lines starting at line 490; frame period 840000 clocks.
- Defaults, h=5,v=7 -> XRead=2, YRead=3. readValueMemory=3'b101 returned one tick later -> R=FF, G=00, B=FF, blank=1, aligned to the delayed h=5 slot.
- screenX=300, border_color=24'h123456 -> display columns 600..639 show 12/34/56 with blank=1, XRead=YRead=0; columns 640..799 show RGB=0, blank=0.
- READ_LATENCY=3, CLK_DIV=1 -> first pins activity (blank=1) 3 ticks after address 0,0 issued; frame_start pulses on the same clock; hsync edge shifted by 3 ticks versus the undelayed counter.
- ColorBits=6, SYNC_POL=1 -> pixel 6'b10_01_11 gives AA/55/FF; hsync/vsync idle low and pulse high.
- Reset asserted mid-line at h=300,v=100 -> next clock all outputs at reset values. After release, counting resumes from 0,0 and frame_start pulses at the first output slot.
